// File: rtl/rca_seq_adder.sv
// Nibble-serial adder: one 4-bit ripple-carry adder reused over WIDTH/4 cycles,
// with a carry register between nibbles and a result held until the next completion.

module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[4];
endmodule

module rca_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, psum_q, psum_nxt;
  logic [IW-1:0]    idx;
  logic             carry_q;
  logic [3:0]       nib_s;
  logic             nib_c;
  logic             accept, step;

  ripple_carry_adder u_rca (
    .a    (a_q[idx*4 +: 4]),
    .b    (b_q[idx*4 +: 4]),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_c)
  );

  // Partial sum with the current nibble merged in, so the last step can
  // publish the complete result on the same edge it is produced.
  always_comb begin
    psum_nxt = psum_q;
    psum_nxt[idx*4 +: 4] = nib_s;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (idx == LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      psum_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        carry_q <= cin;
        idx     <= '0;
      end
      if (step) begin
        psum_q  <= psum_nxt;
        carry_q <= nib_c;
        idx     <= idx + 1'b1;
        if (idx == LAST) begin
          sum  <= psum_nxt;
          cout <= nib_c;
          ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[3] != a_q[WIDTH-1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_rca_seq_adder.sv
// Scoreboard bench for rca_seq_adder at WIDTH=16: expected results queued at
// start, popped on each done pulse; latency, abort and reset checked inline.

module tb_rca_seq_adder;
  localparam int W = 16;
  localparam int N = W / 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst, start, abort, cin;
  logic [W-1:0] a, b;
  logic         ready, done, cout, ovf;
  logic [W-1:0] sum;

  res_t sb[$];
  res_t last;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   exp_done = 0;

  rca_seq_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .a(a), .b(b), .cin(cin),
    .ready(ready), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    res_t       r;
    logic [W:0] t;
    t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return r;
  endfunction

  // Result pops on done; between pulses the outputs must hold the last result.
  always @(negedge clk) begin
    res_t e;
    if (!rst) begin
      if (done) begin
        n_done++;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("sum", sum, e.sum);
          chk("cout", cout, e.cout);
          chk("ovf", ovf, e.ovf);
          last = e;
        end
      end else begin
        chk("hold_sum", sum, last.sum);
        chk("hold_flags", {cout, ovf}, {last.cout, last.ovf});
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_wait", ready, 1);
  endtask

  // mode: 0 plain, 1 ignored start mid-run, 2 abort, 3 reset mid-run,
  //       4 start held high, 5 abort asserted in IDLE and DONE
  task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input int mode);
    wait_ready();
    a = av; b = bv; cin = cv; start = 1'b1;
    if (mode == 5) abort = 1'b1;
    sb.push_back(model(av, bv, cv));
    @(posedge clk); #1;
    if (mode != 4) start = 1'b0;
    abort = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int e = 1; e <= N + 1; e++) begin
      if (mode == 1 && e == 2) begin
        start = 1'b1; a = 16'h1111; b = 16'h1111; cin = 1'b1;
      end
      if (mode == 2 && e == 3) abort = 1'b1;
      if (mode == 3 && e == 3) begin
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", ready, 1);
        chk("arst_done", done, 0);
        chk("arst_sum", sum, 0);
        chk("arst_flags", {cout, ovf}, 0);
        void'(sb.pop_back());
        last = '0;
        #2 rst = 1'b0;
        return;
      end
      if (mode == 5 && e == N + 1) abort = 1'b1;
      @(posedge clk); #1;
      if (mode == 1) start = 1'b0;
      abort = 1'b0;
      if (mode == 2 && e == 3) begin
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, last.sum);
        chk("abort_flags", {cout, ovf}, {last.cout, last.ovf});
        void'(sb.pop_back());
        return;
      end
      chk("lat_done", done, (e == N) ? 1 : 0);
      chk("lat_ready", ready, (e == N + 1) ? 1 : 0);
    end
    exp_done++;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0; cin = 1'b0;
    last = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, ovf}, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    do_add(16'hFFFF, 16'h0001, 1'b0, 0);
    do_add(16'h7FFF, 16'h0001, 1'b0, 0);
    do_add(16'h1234, 16'h4321, 1'b1, 5);
    do_add(16'h8000, 16'h8000, 1'b0, 1);
    do_add(16'h00FF, 16'h0F00, 1'b0, 2);
    do_add(16'h4444, 16'h1111, 1'b0, 3);
    do_add(16'h0F0F, 16'hF0F1, 1'b0, 0);
    for (int k = 0; k < 6; k++)
      do_add(W'($urandom), W'($urandom), 1'($urandom), 4);
    start = 1'b0;
    for (int k = 0; k < 6; k++)
      do_add(W'($urandom), W'($urandom), 1'($urandom), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_left", sb.size(), 0);
    chk("done_count", n_done, exp_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
